// File: rtl/mr_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mr_timer_pkg
//  Purpose  : Shared definitions for the Wishbone machine-timer block:
//             register offsets, CTRL/STATUS field positions, CTRL layout.
//  Revision : 1.0  initial release
// ============================================================================
package mr_timer_pkg;

  localparam int TIMER_XLEN       = 32;
  localparam int TIMER_PRESCALE_W = 8;

  // Word offsets decoded from addr_i[2:0]; 6 and 7 are unmapped
  localparam logic [2:0] c_MTIME_LO = 3'd0;
  localparam logic [2:0] c_MTIME_HI = 3'd1;
  localparam logic [2:0] c_CMP_LO   = 3'd2;
  localparam logic [2:0] c_CMP_HI   = 3'd3;
  localparam logic [2:0] c_CTRL     = 3'd4;
  localparam logic [2:0] c_STATUS   = 3'd5;

  // CTRL / STATUS bit positions
  localparam int c_CTRL_EN_BIT     = 0;
  localparam int c_CTRL_PS_LSB     = 8;
  localparam int c_STATUS_IRQ_BIT  = 0;
  localparam int c_STATUS_CMPW_BIT = 1;

  // CTRL register layout; reserved fields read back as zero
  typedef struct packed {
    logic [TIMER_XLEN-TIMER_PRESCALE_W-9:0] rsvd_hi;
    logic [TIMER_PRESCALE_W-1:0]            prescale;
    logic [6:0]                             rsvd_lo;
    logic                                   enable;
  } ctrl_t;

  // True for the two halves of the live counter
  function automatic logic is_mtime_off(input logic [2:0] off);
    return (off == c_MTIME_LO) || (off == c_MTIME_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mr_wb_timer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mr_wb_timer_if
//  Purpose  : Wishbone pipelined bus bundle between the address decode
//             (master) and the machine timer (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface mr_wb_timer_if #(
  parameter int XLEN      = 32,
  parameter int XLEN_GRAN = 2
) ();

  logic [XLEN-XLEN_GRAN-1:0] addr_i;
  logic [XLEN-1:0]           dat_i;
  logic [XLEN/8-1:0]         sel_i;
  logic                      we_i;
  logic                      stb_i;
  logic                      cyc_i;
  logic [XLEN-1:0]           dat_o;
  logic                      ack_o;
  logic                      err_o;
  logic                      stall_o;

  modport slave (
    input  addr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o, stall_o
  );

  modport master (
    output addr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o, stall_o
  );

endinterface
`default_nettype wire

// File: rtl/mr_bytemask_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mr_bytemask_reg
//  Purpose  : XLEN-wide register with byte-lane bus writes and an optional
//             full-word load path. A bus write has priority over the load.
//  Revision : 1.0  initial release
// ============================================================================
module mr_bytemask_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_we,
  input  wire logic [XLEN/8-1:0] i_sel,
  input  wire logic [XLEN-1:0]   i_wdata,
  input  wire logic              i_load,
  input  wire logic [XLEN-1:0]   i_load_val,
  output logic      [XLEN-1:0]   o_q
);

  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] w_merged;
  logic [XLEN-1:0] w_nxt;

  // Unselected lanes keep their current contents
  for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
    assign w_merged[gi*8 +: 8] = i_sel[gi] ? i_wdata[gi*8 +: 8] : r_q[gi*8 +: 8];
  end

  // Bus write beats the load path
  always_comb begin
    w_nxt = r_q;
    if (i_we)
      w_nxt = w_merged;
    else if (i_load)
      w_nxt = i_load_val;
  end

  // Storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_q <= RESET_VAL;
    else
      r_q <= w_nxt;
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mr_wb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mr_wb_timer
//  Purpose  : Wishbone pipelined slave providing a RISC-V machine timer
//             (64-bit mtime / mtimecmp) and a level timer interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module mr_wb_timer
  import mr_timer_pkg::*;
#(
  parameter int          XLEN       = TIMER_XLEN,
  parameter int          XLEN_GRAN  = 2,
  parameter int          PRESCALE_W = TIMER_PRESCALE_W,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  wire logic    clk,
  input  wire logic    rst,
  mr_wb_timer_if.slave wb,
  output logic         timer_irq_o
);

  // ---------------------------------------------------------------- decode
  logic       w_accept;
  logic       w_rd;
  logic       w_wr;
  logic       w_mapped;
  logic       w_sel_any;
  logic [2:0] w_off;

  assign w_accept  = wb.cyc_i & wb.stb_i;
  assign w_off     = wb.addr_i[2:0];
  assign w_rd      = w_accept & ~wb.we_i;
  assign w_wr      = w_accept &  wb.we_i;
  assign w_mapped  = (w_off <= c_STATUS);
  assign w_sel_any = |wb.sel_i;

  // A write touching at least one byte of mtime suppresses this cycle's increment
  logic w_mtime_wr;
  logic w_cmp_wr;
  assign w_mtime_wr = w_wr & w_sel_any & is_mtime_off(w_off);
  assign w_cmp_wr   = w_wr & w_sel_any & ((w_off == c_CMP_LO) | (w_off == c_CMP_HI));

  // ---------------------------------------------------------------- registers
  logic [XLEN-1:0] r_mtime_lo;
  logic [XLEN-1:0] r_mtime_hi;
  logic [XLEN-1:0] r_cmp_lo;
  logic [XLEN-1:0] r_cmp_hi;
  logic [XLEN-1:0] r_ctrl_raw;
  logic [63:0]     w_mtime;
  logic [63:0]     w_cmp;
  logic [63:0]     w_mtime_inc;
  logic            w_tick;
  logic            w_mtime_load;

  assign w_mtime      = {r_mtime_hi, r_mtime_lo};
  assign w_cmp        = {r_cmp_hi, r_cmp_lo};
  assign w_mtime_inc  = w_mtime + 64'd1;
  assign w_mtime_load = w_tick & ~w_mtime_wr;

  mr_bytemask_reg #(.XLEN(XLEN), .RESET_VAL('0)) u_mtime_lo (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_wr & (w_off == c_MTIME_LO)),
    .i_sel      (wb.sel_i),
    .i_wdata    (wb.dat_i),
    .i_load     (w_mtime_load),
    .i_load_val (w_mtime_inc[31:0]),
    .o_q        (r_mtime_lo)
  );

  mr_bytemask_reg #(.XLEN(XLEN), .RESET_VAL('0)) u_mtime_hi (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_wr & (w_off == c_MTIME_HI)),
    .i_sel      (wb.sel_i),
    .i_wdata    (wb.dat_i),
    .i_load     (w_mtime_load),
    .i_load_val (w_mtime_inc[63:32]),
    .o_q        (r_mtime_hi)
  );

  mr_bytemask_reg #(.XLEN(XLEN), .RESET_VAL(CMP_RESET[31:0])) u_cmp_lo (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_wr & (w_off == c_CMP_LO)),
    .i_sel      (wb.sel_i),
    .i_wdata    (wb.dat_i),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_q        (r_cmp_lo)
  );

  mr_bytemask_reg #(.XLEN(XLEN), .RESET_VAL(CMP_RESET[63:32])) u_cmp_hi (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_wr & (w_off == c_CMP_HI)),
    .i_sel      (wb.sel_i),
    .i_wdata    (wb.dat_i),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_q        (r_cmp_hi)
  );

  mr_bytemask_reg #(.XLEN(XLEN), .RESET_VAL('0)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_wr & (w_off == c_CTRL)),
    .i_sel      (wb.sel_i),
    .i_wdata    (wb.dat_i),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_q        (r_ctrl_raw)
  );

  ctrl_t w_ctrl;
  ctrl_t w_ctrl_rd;
  logic  w_en;
  assign w_ctrl = ctrl_t'(r_ctrl_raw);
  assign w_en   = w_ctrl.enable;

  always_comb begin
    w_ctrl_rd         = w_ctrl;
    w_ctrl_rd.rsvd_hi = '0;
    w_ctrl_rd.rsvd_lo = '0;
  end

  // ---------------------------------------------------------------- prescaler
  // ">=" rather than "==" so that lowering prescale below a frozen divider
  // value ticks immediately instead of waiting for the divider to wrap.
  logic [PRESCALE_W-1:0] r_div;
  assign w_tick = w_en & (r_div >= w_ctrl.prescale);

  // Divider advances only while enabled; frozen (not cleared) when disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_div <= '0;
    else if (w_en)
      r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  // ---------------------------------------------------------------- hi shadow
  logic [XLEN-1:0] r_hi_shadow;

  // Reading MTIME_LO snapshots the upper half for a tear-free 64-bit read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_hi_shadow <= '0;
    else if (w_rd && (w_off == c_MTIME_LO))
      r_hi_shadow <= r_mtime_hi;
  end

  // ---------------------------------------------------------------- interrupt
  logic r_irq;
  logic r_cmp_wflag;
  logic w_irq_nxt;

  assign w_irq_nxt = w_en & (w_mtime >= w_cmp);

  // Level interrupt from the registered counter/compare state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_irq <= 1'b0;
    else
      r_irq <= w_irq_nxt;
  end

  // Records a compare write since the interrupt last rose; a write wins a tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cmp_wflag <= 1'b0;
    else if (w_cmp_wr)
      r_cmp_wflag <= 1'b1;
    else if (w_irq_nxt && !r_irq)
      r_cmp_wflag <= 1'b0;
  end

  assign timer_irq_o = r_irq;

  // ---------------------------------------------------------------- read mux
  logic [XLEN-1:0] w_rd_val;

  // Register value seen at the accept edge
  always_comb begin
    w_rd_val = '0;
    unique case (w_off)
      c_MTIME_LO: w_rd_val = r_mtime_lo;
      c_MTIME_HI: w_rd_val = r_hi_shadow;
      c_CMP_LO:   w_rd_val = r_cmp_lo;
      c_CMP_HI:   w_rd_val = r_cmp_hi;
      c_CTRL:     w_rd_val = w_ctrl_rd;
      c_STATUS: begin
        w_rd_val[c_STATUS_IRQ_BIT]  = r_irq;
        w_rd_val[c_STATUS_CMPW_BIT] = r_cmp_wflag;
      end
      default:    w_rd_val = '0;
    endcase
  end

  // ---------------------------------------------------------------- response
  logic            r_ack;
  logic            r_err;
  logic [XLEN-1:0] r_dat;

  // One registered response per accepted strobe; dat_o zero unless a mapped read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_accept &  w_mapped;
      r_err <= w_accept & ~w_mapped;
      r_dat <= (w_rd && w_mapped) ? w_rd_val : '0;
    end
  end

  assign wb.ack_o   = r_ack;
  assign wb.err_o   = r_err;
  assign wb.dat_o   = r_dat;
  assign wb.stall_o = 1'b0;

  // Bits intentionally not decoded
  logic w_unused;
  assign w_unused = ^{wb.addr_i[XLEN-XLEN_GRAN-1:3], w_ctrl.rsvd_hi, w_ctrl.rsvd_lo};

endmodule
`default_nettype wire

// File: tb/tb_mr_wb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mr_wb_timer
//  Purpose  : Self-checking bench for mr_wb_timer; a cycle model predicts
//             each bus response into a scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mr_wb_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic timer_irq_o;

  always #5 clk = ~clk;

  mr_wb_timer_if #(.XLEN(32), .XLEN_GRAN(2)) wb ();

  mr_wb_timer #(
    .XLEN       (32),
    .XLEN_GRAN  (2),
    .PRESCALE_W (8),
    .CMP_RESET  (64'hFFFF_FFFF_FFFF_FFFF)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb),
    .timer_irq_o (timer_irq_o)
  );

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } resp_t;

  resp_t sb_q[$];

  // Reference model state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic [31:0] m_ctrl;
  logic [7:0]  m_div;
  logic [31:0] m_shadow;
  logic        m_irq;
  logic        m_flag;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_ctrl   = 32'd0;
    m_div    = 8'd0;
    m_shadow = 32'd0;
    m_irq    = 1'b0;
    m_flag   = 1'b0;
  endtask

  function automatic resp_t model_resp(input logic we, input logic [2:0] off);
    resp_t r;
    r.ack = (off <= 3'd5);
    r.err = (off > 3'd5);
    r.dat = 32'd0;
    if (!we) begin
      case (off)
        3'd0: r.dat = m_mtime[31:0];
        3'd1: r.dat = m_shadow;
        3'd2: r.dat = m_cmp[31:0];
        3'd3: r.dat = m_cmp[63:32];
        3'd4: r.dat = {16'd0, m_ctrl[15:8], 7'd0, m_ctrl[0]};
        3'd5: r.dat = {30'd0, m_flag, m_irq};
        default: r.dat = 32'd0;
      endcase
    end
    return r;
  endfunction

  task automatic model_advance(input logic acc, input logic we, input logic [2:0] off,
                               input logic [3:0] sel, input logic [31:0] dat);
    logic [63:0] mt_n, cmp_n;
    logic [31:0] ctrl_n, sh_n;
    logic [7:0]  div_n;
    logic        en, tick, wr, mt_wr, cmp_wr, irq_n, flag_n;
    en     = m_ctrl[0];
    tick   = en && (m_div >= m_ctrl[15:8]);
    wr     = acc && we;
    mt_wr  = wr && (sel != 4'd0) && (off == 3'd0 || off == 3'd1);
    cmp_wr = wr && (sel != 4'd0) && (off == 3'd2 || off == 3'd3);
    div_n  = en ? (tick ? 8'd0 : m_div + 8'd1) : m_div;
    mt_n   = m_mtime;
    if (mt_wr) begin
      if (off == 3'd0) mt_n[31:0]  = merge32(m_mtime[31:0], dat, sel);
      else             mt_n[63:32] = merge32(m_mtime[63:32], dat, sel);
    end else if (tick) begin
      mt_n = m_mtime + 64'd1;
    end
    cmp_n = m_cmp;
    if (wr && off == 3'd2) cmp_n[31:0]  = merge32(m_cmp[31:0], dat, sel);
    if (wr && off == 3'd3) cmp_n[63:32] = merge32(m_cmp[63:32], dat, sel);
    ctrl_n = (wr && off == 3'd4) ? merge32(m_ctrl, dat, sel) : m_ctrl;
    sh_n   = (acc && !we && off == 3'd0) ? m_mtime[63:32] : m_shadow;
    irq_n  = en && (m_mtime >= m_cmp);
    flag_n = cmp_wr ? 1'b1 : ((irq_n && !m_irq) ? 1'b0 : m_flag);
    m_mtime = mt_n; m_cmp = cmp_n; m_ctrl = ctrl_n; m_div = div_n;
    m_shadow = sh_n; m_irq = irq_n; m_flag = flag_n;
  endtask

  // One clock cycle: drive, predict, then check the response at the negedge
  task automatic bus_cycle(input logic acc, input logic we, input logic [2:0] off,
                           input logic [3:0] sel, input logic [31:0] dat, input string tag);
    resp_t r;
    wb.cyc_i  = acc;
    wb.stb_i  = acc;
    wb.we_i   = we;
    wb.addr_i = {27'd0, off};
    wb.sel_i  = sel;
    wb.dat_i  = dat;
    if (acc) sb_q.push_back(model_resp(we, off));
    model_advance(acc, we, off, sel, dat);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      check_val({tag, "_ack"}, wb.ack_o, r.ack);
      check_val({tag, "_err"}, wb.err_o, r.err);
      check_val({tag, "_dat"}, wb.dat_o, r.dat);
    end else begin
      check_val({tag, "_idle_resp"}, {wb.ack_o, wb.err_o}, 2'b00);
    end
    check_val({tag, "_irq"}, timer_irq_o, m_irq);
  endtask

  task automatic rd(input logic [2:0] off, input string tag);
    bus_cycle(1'b1, 1'b0, off, 4'h0, 32'd0, tag);
  endtask

  task automatic wr(input logic [2:0] off, input logic [3:0] sel, input logic [31:0] dat,
                    input string tag);
    bus_cycle(1'b1, 1'b1, off, sel, dat, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 3'd0, 4'h0, 32'd0, "idle");
  endtask

  task automatic hold_reset();
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ack",   wb.ack_o,     1'b0);
    check_val("rst_err",   wb.err_o,     1'b0);
    check_val("rst_dat",   wb.dat_o,     32'd0);
    check_val("rst_irq",   timer_irq_o,  1'b0);
    check_val("rst_stall", wb.stall_o,   1'b0);
    sb_q.delete();
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    wb.addr_i = '0; wb.sel_i = '0; wb.dat_i = '0;
    model_reset();
    @(negedge clk);
    hold_reset();

    // Reset values through the bus
    rd(3'd2, "rst_cmp_lo");
    rd(3'd3, "rst_cmp_hi");
    rd(3'd0, "rst_mt_lo");
    rd(3'd1, "rst_mt_hi");
    rd(3'd4, "rst_ctrl");
    rd(3'd5, "rst_status");

    // Prescale 3: one increment every 4 enabled cycles
    wr(3'd4, 4'hF, 32'h0000_0301, "ctrl_ps3");
    idle(40);
    rd(3'd0, "count_lo");
    rd(3'd4, "ctrl_rb");

    // Reset while counting
    idle(3);
    hold_reset();
    rd(3'd2, "rst2_cmp_lo");
    rd(3'd3, "rst2_cmp_hi");
    rd(3'd0, "rst2_mt_lo");
    rd(3'd1, "rst2_mt_hi");

    // Atomic 64-bit read across a low-word carry
    wr(3'd0, 4'hF, 32'hFFFF_FFFE, "atom_wlo");
    wr(3'd1, 4'hF, 32'h0000_0000, "atom_whi");
    wr(3'd4, 4'hF, 32'h0000_0001, "atom_en");
    rd(3'd0, "atom_lo");
    idle(5);
    rd(3'd1, "atom_hi");

    // Back-to-back accesses, unmapped offsets, byte lanes
    wr(3'd4, 4'hF, 32'd0, "bus_dis");
    rd(3'd0, "b2b_0");
    rd(3'd4, "b2b_4");
    rd(3'd6, "b2b_6");
    rd(3'd5, "b2b_5");
    wr(3'd7, 4'hF, 32'hDEAD_BEEF, "wr_unmapped");
    wr(3'd5, 4'hF, 32'hFFFF_FFFF, "wr_status");
    wr(3'd2, 4'hF, 32'h1234_5678, "cmp_full");
    wr(3'd2, 4'b0010, 32'h0000_AB00, "cmp_byte1");
    rd(3'd2, "cmp_byte1_rb");
    wr(3'd2, 4'b0000, 32'hFFFF_FFFF, "cmp_sel0");
    rd(3'd2, "cmp_sel0_rb");

    // Interrupt rise at compare match, fall after raising mtimecmp
    wr(3'd0, 4'hF, 32'd100, "irq_mlo");
    wr(3'd1, 4'hF, 32'd0,   "irq_mhi");
    wr(3'd2, 4'hF, 32'd105, "irq_clo");
    wr(3'd3, 4'hF, 32'd0,   "irq_chi");
    wr(3'd4, 4'hF, 32'd1,   "irq_en");
    idle(10);
    rd(3'd5, "irq_status");
    wr(3'd3, 4'hF, 32'd1, "irq_raise_cmp");
    idle(3);
    rd(3'd5, "irq_status2");

    // Write collision with a tick: no carry into unwritten bytes
    wr(3'd4, 4'hF, 32'd0,          "col_dis");
    wr(3'd0, 4'hF, 32'h0000_01FF,  "col_lo");
    wr(3'd1, 4'hF, 32'd0,          "col_hi");
    wr(3'd4, 4'hF, 32'd1,          "col_en");
    wr(3'd0, 4'b0001, 32'h10,      "col_wr");
    rd(3'd0, "col_rd_lo");
    rd(3'd1, "col_rd_hi");

    // 64-bit wrap
    wr(3'd4, 4'hF, 32'd0,         "wrap_dis");
    wr(3'd0, 4'hF, 32'hFFFF_FFFF, "wrap_lo");
    wr(3'd1, 4'hF, 32'hFFFF_FFFF, "wrap_hi");
    wr(3'd4, 4'hF, 32'd1,         "wrap_en");
    idle(2);
    rd(3'd0, "wrap_rd_lo");
    rd(3'd1, "wrap_rd_hi");
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
